wheel_pulse_conditioner: RTL and testbench
==========================================

Name: wheel_pulse_conditioner

Overview:
Upstream stage of distance_fare. Conditions the raw wheel-rotation sensor input and produces the ten-metre pulse that distance_fare counts on. Also produces the wait flag (vehicle stopped) that freezes distance and fare accumulation, and a one-second tick for waiting-time charging. All outputs are registered and glitch-free, because distance_fare clocks on ten_meter_pulse.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; also the period of wait_sec_tick in cycles.
SYNC_STAGES, 2, number of flip-flops in the metastability synchroniser on wheel_raw (minimum 2).
DEBOUNCE_CYCLES, 50_000, consecutive stable synchronised samples needed before the debounced level changes (1 ms at 50 MHz).
STOP_TIMEOUT_CYCLES, 50_000_000, cycles with no wheel edge before the vehicle is declared stopped.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  meter running (same signal that drives distance_fare en).
wheel_raw  input  1  asynchronous wheel sensor, one high pulse per wheel sensor mark.
pulses_per_10m  input  4  wheel edges per 10 m, binary; 0 is treated as 1.
ten_meter_pulse  output  1  high for exactly one clk cycle per 10 m travelled.
wait_en  output  1  high while the vehicle is in the STOPPED state.
wait_sec_tick  output  1  one-cycle pulse per CLK_HZ cycles while wait_en is high.
wheel_edge  output  1  one-cycle pulse on each debounced rising edge (debug/verification).

Behaviour:
- Reset (rst=1 at a clk edge): synchroniser, debounce counter, pulse counter, idle counter and second counter are cleared. Debounced level = 0, FSM = MOVING. All outputs are 0 on the following cycle. Reset mid-count discards the partial count with no pulse.
- Synchroniser: SYNC_STAGES flip-flop chain on wheel_raw.
- Debounce:
  - The counter increments while the synchronised sample differs from the debounced level, and clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the sample still differs, the debounced level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- wheel_edge: registered, high the cycle after the debounced level goes 0->1. Latency from a stable raw rise to wheel_edge is SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles (±1 allowed, but fixed for the implementation and documented in the RTL header).
- Pulse counter (4-bit):
  - en=0: counter held at 0 and ten_meter_pulse held at 0.
  - en=1 and wheel_edge: if count >= eff_ppm-1, where eff_ppm = (pulses_per_10m==0 ? 1 : pulses_per_10m), then count<=0 and ten_meter_pulse=1 on the next cycle. Otherwise count<=count+1.
  - The >= comparison makes a mid-count decrease of pulses_per_10m emit on the next edge rather than wrap.
  - ten_meter_pulse is never high on two consecutive cycles.
- Wait FSM, states MOVING and STOPPED:
  - MOVING: the idle counter clears on wheel_edge, otherwise increments. When it reaches STOP_TIMEOUT_CYCLES-1 with no edge, go to STOPPED. wait_en=1 from the next cycle, and the second counter clears.
  - STOPPED: on wheel_edge go to MOVING; wait_en=0 next cycle; the idle counter clears. That same edge still counts toward distance.
  - en=0: FSM forced to MOVING, idle counter and second counter cleared, wait_en=0. A new fare after en rises starts timing from zero.
  - Simultaneous timeout completion and wheel_edge: the edge wins and the FSM stays MOVING.
- wait_sec_tick: in STOPPED the second counter increments each cycle. At CLK_HZ-1 it emits a one-cycle tick and wraps to 0. The first tick comes CLK_HZ cycles after wait_en rises. No tick is emitted in MOVING.
- Counter widths are derived with $clog2 from the parameters. No counter may wrap except the second counter's defined wrap.

Decomposition:
- Shared package taxi_pkg holds: the wait FSM state enum (MOVING, STOPPED), default CLK_HZ, and the default debounce and stop-timeout constants.
- One sub-module, wheel_debounce (synchroniser + debounce + rising-edge detect, outputs wheel_edge). It is reusable for the front-panel buttons.
- Counters and the FSM stay in the top level.

Test Plan:
(bench parameters: CLK_HZ=20, DEBOUNCE_CYCLES=4, STOP_TIMEOUT_CYCLES=100, SYNC_STAGES=2)
1. rst for 3 cycles, then hold wheel_raw=0 -> all outputs 0; no wheel_edge for 50 cycles.
2. en=1, ppm=4, eight clean raw pulses (10 cycles high, 10 cycles low) -> 8 wheel_edge pulses; exactly 2 ten_meter_pulse, each 1 cycle wide, each 1 cycle after the 4th and 8th wheel_edge.
3. Raw glitches of 3 cycles high, then a 10-cycle pulse -> exactly one wheel_edge, occurring 7±1 cycles after the long pulse's rise.
4. en=1, no edges for 100 cycles -> wait_en rises; wait_sec_tick at +20, +40, +60 cycles. A wheel pulse then drops wait_en one cycle after wheel_edge, with no further ticks.
5. ppm=0 -> ten_meter_pulse after every wheel_edge. ppm changed 8->2 after 5 edges -> pulse on the 6th edge, then every 2 edges.
6. en dropped at pulse count 3 and while STOPPED -> wait_en=0 next cycle, counter cleared. rst asserted mid-debounce -> no wheel_edge, and all outputs 0 the next cycle.

Source files
------------

// File: rtl/taxi_pkg.sv
// Shared types and defaults for the taxi meter wheel-pulse front end.
// Latency: n/a (package only).
// Backpressure: n/a.
package taxi_pkg;

    // Wait FSM: the vehicle is either moving or declared stopped.
    typedef enum logic {
        MOVING  = 1'b0,
        STOPPED = 1'b1
    } wait_state_t;

    localparam int DEF_CLK_HZ              = 50_000_000;
    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_DEBOUNCE_CYCLES     = 50_000;
    localparam int DEF_STOP_TIMEOUT_CYCLES = 50_000_000;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wheel_pulse_conditioner_if.sv
// Bundles the meter-side controls and conditioned wheel outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
//   master: drives en, wheel_raw, pulses_per_10m; observes outputs.
//   slave : the conditioner; observes controls, drives outputs.
interface wheel_pulse_conditioner_if;
    logic       en;
    logic       wheel_raw;
    logic [3:0] pulses_per_10m;
    logic       ten_meter_pulse;
    logic       wait_en;
    logic       wait_sec_tick;
    logic       wheel_edge;

    modport master (
        output en, wheel_raw, pulses_per_10m,
        input  ten_meter_pulse, wait_en, wait_sec_tick, wheel_edge
    );

    modport slave (
        input  en, wheel_raw, pulses_per_10m,
        output ten_meter_pulse, wait_en, wait_sec_tick, wheel_edge
    );
endinterface

// File: rtl/wheel_pulse_conditioner_debounce.sv
// Synchroniser + debounce + rising-edge detect for a slow mechanical/sensor input.
// Latency: raw rise sampled at edge N -> rise_pulse high after edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
// Backpressure: none; rise_pulse is a one-cycle registered pulse.
//   Ports: clk, rst (sync, active-high), raw_in (async), rise_pulse (out).
module wheel_debounce
    import taxi_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic rise_pulse
);
    localparam int            DW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          db_cnt;
    logic                   level_q;
    logic                   level_seen_q;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            db_cnt       <= '0;
            level_q      <= 1'b0;
            level_seen_q <= 1'b0;
            rise_pulse   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
            // Any sample agreeing with the current level restarts the run,
            // so only an uninterrupted run of DEBOUNCE_CYCLES flips it.
            if (sample == level_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level_q <= ~level_q;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
            level_seen_q <= level_q;
            rise_pulse   <= level_q & ~level_seen_q;
        end
    end
endmodule

// File: rtl/wheel_pulse_conditioner.sv
// Turns raw wheel marks into a 10 m pulse, a stopped flag and a 1 s waiting tick.
// Latency: wheel_edge SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after a stable raw rise
//          (counted from the edge before the raw change is first sampled);
//          ten_meter_pulse 1 cycle after the qualifying wheel_edge.
// Backpressure: none; every output is registered and glitch-free.
//   Ports: clk, rst (sync, active-high), bus (slave modport: en, wheel_raw,
//   pulses_per_10m in; ten_meter_pulse, wait_en, wait_sec_tick, wheel_edge out).
module wheel_pulse_conditioner
    import taxi_pkg::*;
#(
    parameter int CLK_HZ              = DEF_CLK_HZ,
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int STOP_TIMEOUT_CYCLES = DEF_STOP_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    wheel_pulse_conditioner_if.slave   bus
);
    localparam int            IW        = cnt_width(STOP_TIMEOUT_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(STOP_TIMEOUT_CYCLES - 1);
    localparam int            SW        = cnt_width(CLK_HZ);
    localparam logic [SW-1:0] SEC_LAST  = SW'(CLK_HZ - 1);

    logic          wheel_edge;
    logic [3:0]    pulse_cnt;
    logic [3:0]    eff_last;
    logic [IW-1:0] idle_cnt;
    logic [SW-1:0] sec_cnt;
    wait_state_t   state;
    logic          ten_q;
    logic          wait_q;
    logic          tick_q;

    wheel_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (bus.wheel_raw),
        .rise_pulse (wheel_edge)
    );

    // Last count value before a 10 m pulse; a setting of 0 behaves as 1.
    always_comb begin
        eff_last = 4'd0;
        if (bus.pulses_per_10m != 4'd0) begin
            eff_last = bus.pulses_per_10m - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_cnt <= '0;
            idle_cnt  <= '0;
            sec_cnt   <= '0;
            state     <= MOVING;
            ten_q     <= 1'b0;
            wait_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else if (!bus.en) begin
            // Meter idle: every new fare starts distance and wait timing from zero.
            pulse_cnt <= '0;
            idle_cnt  <= '0;
            sec_cnt   <= '0;
            state     <= MOVING;
            ten_q     <= 1'b0;
            wait_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            ten_q  <= 1'b0;
            tick_q <= 1'b0;

            // >= so that lowering pulses_per_10m mid-count fires on the next
            // edge instead of running up to 15 and wrapping.
            if (wheel_edge) begin
                if (pulse_cnt >= eff_last) begin
                    pulse_cnt <= '0;
                    ten_q     <= 1'b1;
                end else begin
                    pulse_cnt <= pulse_cnt + 4'd1;
                end
            end

            case (state)
                MOVING: begin
                    // An edge coinciding with timeout keeps us moving.
                    if (wheel_edge) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state    <= STOPPED;
                        wait_q   <= 1'b1;
                        idle_cnt <= '0;
                        sec_cnt  <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                STOPPED: begin
                    // Leaving on an edge suppresses a tick due that same cycle.
                    if (wheel_edge) begin
                        state    <= MOVING;
                        wait_q   <= 1'b0;
                        idle_cnt <= '0;
                        sec_cnt  <= '0;
                    end else if (sec_cnt == SEC_LAST) begin
                        sec_cnt <= '0;
                        tick_q  <= 1'b1;
                    end else begin
                        sec_cnt <= sec_cnt + SW'(1);
                    end
                end
                default: state <= MOVING;
            endcase
        end
    end

    assign bus.wheel_edge      = wheel_edge;
    assign bus.ten_meter_pulse = ten_q;
    assign bus.wait_en         = wait_q;
    assign bus.wait_sec_tick   = tick_q;
endmodule

// File: tb/tb_wheel_pulse_conditioner.sv
// Bench for wheel_pulse_conditioner: directed phases plus random wheel traffic,
// compared every cycle against an event-level reference model.
// Small parameters so that timeouts and seconds complete in a few hundred cycles.
module tb_wheel_pulse_conditioner;
    localparam int P_CLK_HZ = 20;
    localparam int P_SYNC   = 2;
    localparam int P_DEB    = 4;
    localparam int P_STOP   = 100;
    localparam int LAT      = P_SYNC + P_DEB + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wheel_pulse_conditioner_if bus();

    wheel_pulse_conditioner #(
        .CLK_HZ              (P_CLK_HZ),
        .SYNC_STAGES         (P_SYNC),
        .DEBOUNCE_CYCLES     (P_DEB),
        .STOP_TIMEOUT_CYCLES (P_STOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state: scheduled edge cycles, edges in current 10 m group,
    // last activity cycle, stop cycle.
    int edge_q[$];
    int grp     = 0;
    int anchor  = 0;
    int stop_at = 0;
    bit stopped = 1'b0;
    bit prev_edge = 1'b0;

    int obs_edge = 0;
    int obs_ten  = 0;
    int obs_tick = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: capture what the edge saw, then sample outputs and compare.
    task automatic step();
        bit r, e, ee, et, ew, ek;
        int p, eff;
        @(posedge clk);
        cyc++;
        r = rst;
        e = bus.en;
        p = int'(bus.pulses_per_10m);
        #1;
        ee = 1'b0; et = 1'b0; ek = 1'b0;
        if (edge_q.size() > 0 && edge_q[0] == cyc) begin
            ee = 1'b1;
            void'(edge_q.pop_front());
        end
        if (r) begin
            edge_q.delete();
            ee = 1'b0; grp = 0; stopped = 1'b0; anchor = cyc;
        end else if (!e) begin
            grp = 0; stopped = 1'b0; anchor = cyc;
        end else begin
            if (prev_edge) begin
                grp++;
                eff = (p == 0) ? 1 : p;
                if (grp >= eff) begin
                    et = 1'b1;
                    grp = 0;
                end
                stopped = 1'b0;
                anchor = cyc;
            end else if (!stopped) begin
                if (cyc - anchor >= P_STOP) begin
                    stopped = 1'b1;
                    stop_at = cyc;
                end
            end else if ((cyc - stop_at) % P_CLK_HZ == 0) begin
                ek = 1'b1;
            end
        end
        ew = stopped;
        prev_edge = ee;
        chk("wheel_edge", {7'd0, bus.wheel_edge}, {7'd0, ee});
        chk("ten_meter_pulse", {7'd0, bus.ten_meter_pulse}, {7'd0, et});
        chk("wait_en", {7'd0, bus.wait_en}, {7'd0, ew});
        chk("wait_sec_tick", {7'd0, bus.wait_sec_tick}, {7'd0, ek});
        if (bus.wheel_edge === 1'b1) obs_edge++;
        if (bus.ten_meter_pulse === 1'b1) obs_ten++;
        if (bus.wait_sec_tick === 1'b1) obs_tick++;
    endtask

    // Hold wheel_raw at a level for len cycles; a high run of at least the
    // debounce length is expected to produce one edge LAT cycles later.
    task automatic seg(input bit hi, input int len);
        if (hi && len >= P_DEB) edge_q.push_back(cyc + LAT);
        bus.wheel_raw = hi;
        repeat (len) step();
    endtask

    task automatic pulse(input int h, input int l);
        seg(1'b1, h);
        seg(1'b0, l);
    endtask

    task automatic en_restart();
        bus.en = 1'b0;
        step();
        bus.en = 1'b1;
    endtask

    initial begin
        int b_edge, b_ten, b_tick, h;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.wheel_raw = 1'b0;
        bus.pulses_per_10m = 4'd4;

        // Reset, then quiet input.
        repeat (3) step();
        rst = 1'b0;
        b_edge = obs_edge;
        repeat (50) step();
        chk("quiet_edges", 8'(obs_edge - b_edge), 8'd0);

        // Eight clean pulses, 4 per 10 m.
        bus.en = 1'b1;
        b_edge = obs_edge; b_ten = obs_ten;
        repeat (8) pulse(10, 10);
        chk("p2_edges", 8'(obs_edge - b_edge), 8'd8);
        chk("p2_ten", 8'(obs_ten - b_ten), 8'd2);

        // Short glitches rejected, then one real pulse.
        b_edge = obs_edge;
        repeat (3) pulse(3, 6);
        pulse(10, 10);
        chk("p3_edges", 8'(obs_edge - b_edge), 8'd1);

        // Stop timeout, three seconds of waiting, then moving again.
        b_tick = obs_tick;
        en_restart();
        repeat (170) step();
        chk("p4_wait_high", {7'd0, bus.wait_en}, 8'd1);
        chk("p4_ticks", 8'(obs_tick - b_tick), 8'd3);
        pulse(10, 20);
        chk("p4_wait_low", {7'd0, bus.wait_en}, 8'd0);
        chk("p4_ticks_after", 8'(obs_tick - b_tick), 8'd3);

        // pulses_per_10m = 0 acts as 1.
        bus.pulses_per_10m = 4'd0;
        b_ten = obs_ten;
        repeat (4) pulse(6, 6);
        chk("p5_ppm0", 8'(obs_ten - b_ten), 8'd4);

        // 8 -> 2 after five edges: fires on 6th, 8th, 10th.
        bus.pulses_per_10m = 4'd8;
        en_restart();
        b_ten = obs_ten;
        repeat (5) pulse(6, 6);
        chk("p5_ppm8", 8'(obs_ten - b_ten), 8'd0);
        bus.pulses_per_10m = 4'd2;
        repeat (5) pulse(6, 6);
        chk("p5_ppm2", 8'(obs_ten - b_ten), 8'd3);

        // Random wheel traffic with occasional en and ratio changes.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 3) == 0) bus.pulses_per_10m = 4'($urandom_range(0, 15));
            h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 12));
            pulse(h, int'($urandom_range(4, 12)));
            if ($urandom_range(0, 7) == 0) seg(1'b0, int'($urandom_range(90, 140)));
        end

        // en dropped mid-count clears the partial count.
        bus.en = 1'b1;
        bus.pulses_per_10m = 4'd4;
        en_restart();
        repeat (3) pulse(8, 8);
        en_restart();
        b_ten = obs_ten;
        repeat (3) pulse(8, 8);
        chk("p6_partial_cleared", 8'(obs_ten - b_ten), 8'd0);
        pulse(8, 8);
        chk("p6_after_fourth", 8'(obs_ten - b_ten), 8'd1);

        // en dropped while stopped.
        repeat (110) step();
        chk("p6_stopped", {7'd0, bus.wait_en}, 8'd1);
        bus.en = 1'b0;
        step();
        chk("p6_en_drop_wait", {7'd0, bus.wait_en}, 8'd0);
        bus.en = 1'b1;

        // Reset in the middle of debouncing a rise.
        bus.wheel_raw = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        bus.wheel_raw = 1'b0;
        step();
        chk("p6_rst_outputs",
            {4'd0, bus.wheel_edge, bus.ten_meter_pulse, bus.wait_en, bus.wait_sec_tick}, 8'd0);
        rst = 1'b0;
        b_edge = obs_edge;
        repeat (15) step();
        chk("p6_rst_no_edge", 8'(obs_edge - b_edge), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
